encoder_8_to_3: RTL and testbench
=================================

# encoder_8_to_3

Registered 8-to-3 priority encoder: converts an 8-bit request vector into the 3-bit index of its highest set bit, with a valid flag and an optional multi-hot detect. It sits between one-hot/request sources (decoders, arbiters, interrupt lines) and index-consuming logic, giving a clean registered boundary with one cycle of latency.

## Interface
Parameters:
- None. Widths are fixed at 8 inputs / 3 index bits via package constants.

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- en  input  1  sample enable; when low, all outputs hold
- in  input  8  request vector; bit i set means request at index i
- out  output  3  registered index of highest set bit of `in`
- valid  output  1  registered; 1 when sampled `in` was nonzero
- multi  output  1  registered; 1 when sampled `in` had two or more bits set (only with `ENCODER_8_TO_3_MULTI_EN`)

## Operation
- Combinational core: idx = position of most significant 1 in `in` (bit 7 highest priority); any = |in; mh = more than one bit set.
- One-hot input maps exactly: 8'b0000_0001 → 3'd0, 8'b0000_0010 → 1, 8'b0000_0100 → 2, 8'b0000_1000 → 3, 8'b0001_0000 → 4, 8'b0010_0000 → 5, 8'b0100_0000 → 6, 8'b1000_0000 → 7.
- Multi-hot input: highest set bit wins (8'b0010_0101 → 5).
- All-zero input: out ← 3'd0, valid ← 0, multi ← 0.
- en=1 at a rising edge: out ← idx, valid ← any, multi ← mh.
- en=0: out, valid, multi keep previous values regardless of `in`.
- No X-propagation: unknown-free `in` always yields defined outputs.

## Timing
- Latency: 1 cycle; `in` sampled at edge N with en=1 appears on outputs after edge N.
- Throughput: one new encode per cycle; back-to-back inputs each appear one cycle later, in order.
- Reset: assertion forces out=3'd0, valid=0, multi=0 immediately (no clock needed); held while rst=1. First sample occurs at the first rising edge with rst=0 and en=1.
- Reset asserted mid-stream: in-flight result is discarded; outputs go to reset values at once.
- rst and en both high: reset wins.
- No handshake/backpressure; consumer must capture on valid.

## Configuration
- Macro `ENCODER_8_TO_3_MULTI_EN`.
- Defined: `multi` port present and registered as described.
- Undefined: `multi` port and its mh logic absent; out/valid behaviour identical.

## Structure
- Package `encoder_8_to_3_pkg`: localparams IN_W=8, IDX_W=3; typedefs for request vector (logic [IN_W-1:0]) and index (logic [IDX_W-1:0]).
- Sub-module `prio_enc8`: purely combinational, in → idx, any, mh (mh only under macro). Top level holds only the enable/reset register stage.

## Test plan
- Reset: hold rst=1, toggle clk with in=8'hFF, en=1 → out=0, valid=0, multi=0 throughout; assert rst asynchronously mid-cycle → outputs clear before next edge.
- One-hot sweep: en=1, in = 8'h01,02,04,08,10,20,40,80 on consecutive cycles → out = 0..7 one cycle later, valid=1, multi=0.
- Priority: in=8'b0010_0101 → out=5, valid=1, multi=1; in=8'hFF → out=7, multi=1.
- Zero: in=8'h00 after out=7 → out=0, valid=0, multi=0.
- Hold: capture in=8'h10 (out=4), drop en, drive in=8'h02 for 3 cycles → out stays 4, valid stays 1; raise en → out=1 next cycle.
- Macro off: rebuild without `ENCODER_8_TO_3_MULTI_EN`, rerun sweep and priority cases → identical out/valid, no `multi` port.

Source files
------------

// File: rtl/encoder_8_to_3_pkg.sv
// encoder_8_to_3_pkg
//   Shared widths and types for the registered 8-to-3 priority encoder.
//   IN_W  : request vector width
//   IDX_W : encoded index width
package encoder_8_to_3_pkg;

    localparam int IN_W  = 8;
    localparam int IDX_W = 3;

    typedef logic [IN_W-1:0]  req_t;
    typedef logic [IDX_W-1:0] idx_t;

endpackage : encoder_8_to_3_pkg

// File: rtl/encoder_8_to_3_prio_enc8.sv
// prio_enc8
//   Purely combinational 8-input priority encoder; bit 7 has highest priority.
//   Optional feature macro: ENCODER_8_TO_3_MULTI_EN (adds the mh output).
// Ports:
//   req  in   8  request vector
//   idx  out  3  index of the most significant set bit (0 when req is zero)
//   any  out  1  at least one request bit set
//   mh   out  1  two or more request bits set (macro only)
module prio_enc8
    import encoder_8_to_3_pkg::*;
(
    input  req_t req,
    output idx_t idx,
    output logic any
`ifdef ENCODER_8_TO_3_MULTI_EN
    ,
    output logic mh
`endif
);

    // Ascending scan: later (higher) set bits overwrite earlier ones, so the
    // highest set bit wins.
    always_comb begin
        idx = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (req[i]) begin
                idx = idx_t'(i);
            end
        end
    end

    assign any = |req;

`ifdef ENCODER_8_TO_3_MULTI_EN
    // Clearing the lowest set bit leaves something only if another bit was set.
    req_t req_low_cleared;
    assign req_low_cleared = req & (req - req_t'(1));
    assign mh = |req_low_cleared;
`endif

endmodule : prio_enc8

// File: rtl/encoder_8_to_3.sv
// encoder_8_to_3
//   Registered 8-to-3 priority encoder with one cycle of latency.
//   Optional feature macro: ENCODER_8_TO_3_MULTI_EN (adds the multi output).
// Ports:
//   clk    in   1  clock, rising edge
//   rst    in   1  asynchronous active-high reset
//   en     in   1  sample enable; outputs hold while low
//   in     in   8  request vector
//   out    out  3  registered index of highest set bit
//   valid  out  1  registered; sampled vector was nonzero
//   multi  out  1  registered; sampled vector had 2+ bits set (macro only)
module encoder_8_to_3
    import encoder_8_to_3_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  req_t in,
    output idx_t out,
    output logic valid
`ifdef ENCODER_8_TO_3_MULTI_EN
    ,
    output logic multi
`endif
);

    idx_t idx;
    logic any;

`ifdef ENCODER_8_TO_3_MULTI_EN
    logic mh;

    prio_enc8 u_prio_enc8 (
        .req (in),
        .idx (idx),
        .any (any),
        .mh  (mh)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out   <= '0;
            valid <= 1'b0;
            multi <= 1'b0;
        end else if (en) begin
            out   <= idx;
            valid <= any;
            multi <= mh;
        end
    end
`else
    prio_enc8 u_prio_enc8 (
        .req (in),
        .idx (idx),
        .any (any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out   <= '0;
            valid <= 1'b0;
        end else if (en) begin
            out   <= idx;
            valid <= any;
        end
    end
`endif

endmodule : encoder_8_to_3

// File: tb/tb_encoder_8_to_3.sv
// tb_encoder_8_to_3
//   Self-checking bench for encoder_8_to_3 with a behavioural reference model.
//   Builds with or without ENCODER_8_TO_3_MULTI_EN.
module tb_encoder_8_to_3;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] in;
    logic [2:0] out;
    logic       valid;
`ifdef ENCODER_8_TO_3_MULTI_EN
    logic       multi;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] exp_out;
    logic       exp_valid;
    logic       exp_multi;

    always #5 clk = ~clk;

    encoder_8_to_3 dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .in    (in),
        .out   (out),
        .valid (valid)
`ifdef ENCODER_8_TO_3_MULTI_EN
        ,
        .multi (multi)
`endif
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: floor(log2(v)) for v > 0, else 0.
    function automatic int ref_idx(input int v);
        int r = 0;
        while (v > 1) begin
            v = v / 2;
            r++;
        end
        return r;
    endfunction

    function automatic int ref_ones(input int v);
        int c = 0;
        while (v > 0) begin
            c += v % 2;
            v = v / 2;
        end
        return c;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".out"},   {5'd0, out},   {5'd0, exp_out});
        check({tag, ".valid"}, {7'd0, valid}, {7'd0, exp_valid});
`ifdef ENCODER_8_TO_3_MULTI_EN
        check({tag, ".multi"}, {7'd0, multi}, {7'd0, exp_multi});
`endif
    endtask

    // Drive one cycle of stimulus, update the model at the edge, check after.
    task automatic step(input string tag, input logic [7:0] v, input logic e);
        in = v;
        en = e;
        @(posedge clk);
        if (e) begin
            exp_out   = 3'(ref_idx(int'(v)));
            exp_valid = (v != 8'd0);
            exp_multi = (ref_ones(int'(v)) >= 2);
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        logic [7:0] v;
        logic       e;

        rst = 1'b1;
        en  = 1'b1;
        in  = 8'hFF;
        exp_out = 3'd0; exp_valid = 1'b0; exp_multi = 1'b0;
        #1;
        check_outputs("reset_initial");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_outputs("reset_held");
        end
        rst = 1'b0;

        // One-hot sweep
        for (int i = 0; i < 8; i++) begin
            v = 8'd1 << i;
            step("onehot", v, 1'b1);
        end

        // Priority and zero
        step("prio_25", 8'b0010_0101, 1'b1);
        step("prio_ff", 8'hFF, 1'b1);
        step("zero", 8'h00, 1'b1);

        // Hold
        step("hold_cap", 8'h10, 1'b1);
        for (int i = 0; i < 3; i++) step("hold", 8'h02, 1'b0);
        step("hold_release", 8'h02, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            v = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) v = 8'd1 << $urandom_range(0, 7);
            e = ($urandom_range(0, 3) != 0);
            step("random", v, e);
        end

        // Asynchronous reset mid-cycle discards the held result immediately.
        step("pre_async", 8'h80, 1'b1);
        in = 8'hC3;
        #3;
        rst = 1'b1;
        exp_out = 3'd0; exp_valid = 1'b0; exp_multi = 1'b0;
        #1;
        check_outputs("async_reset");
        @(posedge clk);
        #1;
        check_outputs("async_reset_held");
        rst = 1'b0;
        step("post_reset", 8'h41, 1'b1);
        step("post_reset2", 8'h08, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_encoder_8_to_3
